// File: rtl/test_block_pkg.sv
// Shared constants for test_block: output shaping modes and FUNC register field layout.
package test_block_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_FALL   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  localparam int TABLE_LSB = 0;
  localparam int TABLE_W   = 8;
  localparam int MODE_LSB  = 8;
  localparam int MODE_W    = 2;
  localparam int CFG_W     = MODE_LSB + MODE_W;

endpackage

// File: rtl/test_block.sv
// Configurable 3-input truth-table block with optional edge/toggle shaping.
// The registered output OUT_o is the only observable state.
module test_block
  import test_block_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] FUNC,
  input  logic        FUNC_wstb,
  input  logic [1:0]  A,
  input  logic        INPA_i,
  output logic        OUT_o
);

  logic [CFG_W-1:0]   r_func;
  logic               r_prev;
  logic               r_tog;
  logic               r_out;

  logic [CFG_W-1:0]   w_cfg;
  logic [TABLE_W-1:0] w_table;
  mode_e              w_mode;
  logic [2:0]         w_idx;
  logic               w_r;
  logic               w_rise;
  logic               w_fall;
  logic               w_nextTog;
  logic               w_nextOut;
  logic               w_unused;

  // A write is used on the very edge it is captured, so the bus value bypasses func_q.
  assign w_cfg    = FUNC_wstb ? FUNC[CFG_W-1:0] : r_func;
  assign w_table  = w_cfg[TABLE_LSB +: TABLE_W];
  assign w_mode   = mode_e'(w_cfg[MODE_LSB +: MODE_W]);
  assign w_idx    = {A, INPA_i};
  assign w_r      = w_table[w_idx];
  assign w_rise   = w_r & ~r_prev;
  assign w_fall   = ~w_r & r_prev;
  assign w_unused = ^FUNC[31:CFG_W];

  // During a strobe the edge history restarts so a table/mode change cannot pulse.
  always_comb begin
    w_nextTog = r_tog;
    w_nextOut = 1'b0;
    if (FUNC_wstb) begin
      w_nextTog = 1'b0;
      w_nextOut = (w_mode == MODE_LEVEL) ? w_r : 1'b0;
    end else begin
      unique case (w_mode)
        MODE_LEVEL:  w_nextOut = w_r;
        MODE_RISE:   w_nextOut = w_rise;
        MODE_FALL:   w_nextOut = w_fall;
        MODE_TOGGLE: begin
          w_nextTog = r_tog ^ w_rise;
          w_nextOut = r_tog ^ w_rise;
        end
        default:     w_nextOut = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_func <= '0;
      r_prev <= 1'b0;
      r_tog  <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      if (FUNC_wstb) begin
        r_func <= FUNC[CFG_W-1:0];
      end
      r_prev <= w_r;
      r_tog  <= w_nextTog;
      r_out  <= w_nextOut;
    end
  end

  assign OUT_o = r_out;

endmodule

// File: tb/tb_test_block.sv
// Directed scoreboard bench for test_block: each step queues its expected OUT_o,
// which is popped and compared one clock edge later.
module tb_test_block;

  logic        clk;
  logic        resetN;
  logic [31:0] func;
  logic        funcWstb;
  logic [1:0]  selA;
  logic        inpA;
  logic        outO;

  int checks   = 0;
  int failures = 0;
  logic expectQ[$];

  test_block dut (
    .clk_i     (clk),
    .reset_n_i (resetN),
    .FUNC      (func),
    .FUNC_wstb (funcWstb),
    .A         (selA),
    .INPA_i    (inpA),
    .OUT_o     (outO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops the oldest expectation and compares it against OUT_o.
  task automatic checkOutput(input string tag);
    logic expected;
    checks++;
    if (expectQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s observed=%b required=scoreboard-entry", tag, outO);
      return;
    end
    expected = expectQ.pop_front();
    assert (outO === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, outO, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, queues the result, checks after the rising edge.
  task automatic applyStimulus(input logic wstb, input logic [31:0] f, input logic [1:0] a,
                               input logic inp, input logic expected, input string tag);
    @(negedge clk);
    funcWstb = wstb;
    func     = f;
    selA     = a;
    inpA     = inp;
    expectQ.push_back(expected);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [2:0] combo;

    resetN   = 1'b0;
    funcWstb = 1'b0;
    func     = 32'h0;
    selA     = 2'd3;
    inpA     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expectQ.push_back(1'b0);
    checkOutput("reset_hold");

    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'd3, 1'b1, 1'b0, "idle_after_reset_0");
    applyStimulus(1'b0, 32'h0, 2'd3, 1'b1, 1'b0, "idle_after_reset_1");

    // LEVEL AND with junk in the ignored upper FUNC bits
    applyStimulus(1'b1, 32'hABCD_EC80, 2'd0, 1'b0, 1'b0, "and_write");
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      applyStimulus(1'b0, 32'h0, combo[2:1], combo[0], (i == 7), $sformatf("and_sweep_%0d", i));
    end

    // Same-edge write takes effect immediately
    applyStimulus(1'b1, 32'h0000_0002, 2'd0, 1'b1, 1'b1, "same_edge_set");
    applyStimulus(1'b1, 32'h0000_0000, 2'd0, 1'b1, 1'b0, "same_edge_clear");
    applyStimulus(1'b0, 32'h0000_00FF, 2'd0, 1'b1, 1'b0, "unstrobed_func_ignored");

    // RISE: INPA passthrough
    applyStimulus(1'b1, 32'h0000_01AA, 2'd0, 1'b0, 1'b0, "rise_write");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, "rise_pulse");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, $sformatf("rise_hold_%0d", i));
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, "rise_falling_input");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, "rise_low_hold");

    // FALL
    applyStimulus(1'b1, 32'h0000_02AA, 2'd0, 1'b1, 1'b0, "fall_write");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, "fall_pulse");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, "fall_hold");

    // TOGGLE
    applyStimulus(1'b1, 32'h0000_03AA, 2'd0, 1'b0, 1'b0, "tog_write");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, "tog_edge1");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, "tog_low1");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, "tog_edge2");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, "tog_low2");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, "tog_edge3");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, "tog_hold");
    applyStimulus(1'b1, 32'h0000_03AA, 2'd0, 1'b1, 1'b0, "tog_restrobe");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, "tog_cleared");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, "tog_low3");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, "tog_edge_after_clear");

    // Strobe suppression in RISE mode
    applyStimulus(1'b1, 32'h0000_0100, 2'd0, 1'b1, 1'b0, "supp_write_zero");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, "supp_idle");
    applyStimulus(1'b1, 32'h0000_0102, 2'd0, 1'b1, 1'b0, "supp_strobe_edge");
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, "supp_after_strobe");

    // Asynchronous reset mid-stream
    applyStimulus(1'b1, 32'h0000_00FF, 2'd0, 1'b0, 1'b1, "pre_reset_level");
    @(negedge clk);
    funcWstb = 1'b0;
    func     = 32'h0;
    #2;
    resetN = 1'b0;
    #1;
    expectQ.push_back(1'b0);
    checkOutput("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, "post_reset_table_cleared");

    if (expectQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain observed=%0d required=0", expectQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
